parking_gate_scheduler: RTL and testbench
=========================================

// Module: parking_gate_scheduler
// PURPOSE
//  Entry-gate sequencer for the campus parking occupancy block.
//  - Arbitrates N entry lanes round-robin and checks capacity from the occupancy block.
//  - Drives the single shared barrier gate.
//  - Emits the one-cycle car_entered / is_uni_car_entered pulse that the occupancy block counts.
//  - Serialises entries so the occupancy block never sees overlapping events.
// PARAMETERS
//  N_LANES          2    number of entry lanes (>=2)
//  OPEN_TIMEOUT     32   cycles gate stays open waiting for car_passed before abort
//  CLOSE_CYCLES     2    cycles gate is held closed before next arbitration
// PORTS
//  clk                 in   1        system clock, rising edge
//  rst_n               in   1        asynchronous, active-low reset
//  lane_req            in   N_LANES  car waiting at lane i; held until grant/reject
//  lane_is_uni         in   N_LANES  car at lane i holds a university permit
//  parking_open        in   1        1 inside the 08:00-20:00 window
//  uni_vacated_space   in   32       free university slots (unsigned)
//  vacated_space       in   32       free general slots (unsigned)
//  car_passed          in   1        gate sensor, car cleared barrier (level, 1+ cycles)
//  lane_grant          out  N_LANES  one-hot 1-cycle pulse: lane i admitted
//  lane_reject         out  N_LANES  one-hot 1-cycle pulse: lane i refused (full/closed)
//  gate_open           out  1        barrier open command
//  car_entered         out  1        1-cycle pulse per admitted car that passed
//  is_uni_car_entered  out  1        category of that car, valid while car_entered=1
//  busy                out  1        FSM not in IDLE
//  timeout_err         out  1        1-cycle pulse: granted car never passed
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0. All outputs are 0.
//  All outputs are registered.
//  IDLE:
//   - If parking_open and any lane_req: latch winner = first requesting lane at/after rr_ptr.
//   - Latch its is_uni and go to CHECK. Otherwise stay.
//  CHECK (1 cycle):
//   - Eligible = parking_open && ((is_uni && uni_vacated_space!=0) || vacated_space!=0).
//   - A university car overflows into general space.
//   - Eligible: lane_grant[w]=1, gate_open=1, load timeout counter, go to OPEN.
//   - Else: lane_reject[w]=1, go to IDLE.
//   - Either outcome: rr_ptr = (w+1) mod N_LANES.
//  OPEN: gate_open=1. Counter decrements each cycle.
//   - car_passed=1: car_entered=1 and is_uni_car_entered=latched is_uni for the next cycle.
//     gate_open=0 from that cycle. Go to CLOSE.
//   - Counter reaches 0 first: timeout_err pulse, no car_entered, go to CLOSE.
//   - car_passed wins if both occur in the same cycle.
//  CLOSE: gate_open=0 for CLOSE_CYCLES, then IDLE.
//   - A car_passed level still high here is ignored.
//  Latency: req at edge k -> grant/reject high in cycle k+2. car_passed at edge m -> car_entered high in cycle m+1.
//  Boundaries:
//   - car_passed outside OPEN: ignored.
//   - parking_open dropping in OPEN: the admitted car completes normally. In CHECK it forces a reject.
//   - Space reading 0 -> reject. Values are unsigned, never wrap.
//   - Request dropped after latching: the cycle still completes. A grant with no car ends in timeout.
//   - rst_n low mid-operation: gate_open falls immediately (async). No pending pulse is emitted.
//  At most one of lane_grant/lane_reject/car_entered/timeout_err is active per cycle.
// STRUCTURE
//  - parking_pkg holds the state enum (IDLE, CHECK, OPEN, CLOSE), lane/counter width helpers, and default timing constants.
//  - One sub-module, parking_rr_arbiter: N-way round-robin pick (req, ptr -> one-hot winner, index). Combinational.
// TESTING
//  1. Reset: rst_n=0 mid-OPEN -> gate_open=0 at once; after release all outputs 0, busy=0.
//  2. Single lane: lane_req[0]=1, uni=1, uni_vacated=5 -> grant[0] in cycle k+2, gate_open=1.
//     Then car_passed -> car_entered=1, is_uni_car_entered=1 for one cycle.
//  3. Both lanes requesting continuously from reset -> grants alternate 0,1,0,1. No lane starves.
//  4. Overflow/full:
//     - uni car, uni_vacated=0, vacated=3 -> grant.
//     - uni_vacated=0 and vacated=0 -> reject, gate_open stays 0.
//  5. Timeout: grant with no car_passed for 32 cycles -> timeout_err pulse, no car_entered.
//     Gate closes 2 cycles, then IDLE.
//  6. Closed window: parking_open=0 with requests -> no activity.
//     parking_open falling during OPEN -> car completes with car_entered=1.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types, timing defaults and width helpers for the parking entry-gate sequencer.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OPEN  = 2'd2,
    ST_CLOSE = 2'd3
  } gate_state_e;

  localparam int unsigned DEFAULT_N_LANES      = 2;
  localparam int unsigned DEFAULT_OPEN_TIMEOUT = 32;
  localparam int unsigned DEFAULT_CLOSE_CYCLES = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One counter serves both the open-wait and the close-hold phases.
  function automatic int unsigned cnt_width(input int unsigned open_cycles,
                                            input int unsigned close_cycles);
    int unsigned m;
    m = (open_cycles > close_cycles) ? open_cycles : close_cycles;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/parking_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr, wrapping.
module parking_rr_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned N_LANES = DEFAULT_N_LANES,
  parameter int unsigned IDX_W   = idx_width(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_LANES-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    // NOTE: every output gets a default before the loops, so no path infers a latch.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    // Lanes at or after the pointer take priority; lower lanes only on wrap.
    for (int i = 0; i < N_LANES; i++) begin
      if (!valid && req[i] && (IDX_W'(i) >= ptr)) begin
        valid    = 1'b1;
        idx      = IDX_W'(i);
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (!valid && req[i]) begin
        valid    = 1'b1;
        idx      = IDX_W'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Entry-gate sequencer: picks a lane, checks capacity, drives the shared barrier
// and emits one serialised car_entered event per admitted car.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned N_LANES      = DEFAULT_N_LANES,
  parameter int unsigned OPEN_TIMEOUT = DEFAULT_OPEN_TIMEOUT,
  parameter int unsigned CLOSE_CYCLES = DEFAULT_CLOSE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] lane_req,
  input  logic [N_LANES-1:0] lane_is_uni,
  input  logic               parking_open,
  input  logic [31:0]        uni_vacated_space,
  input  logic [31:0]        vacated_space,
  input  logic               car_passed,
  output logic [N_LANES-1:0] lane_grant,
  output logic [N_LANES-1:0] lane_reject,
  output logic               gate_open,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned      IDX_W      = idx_width(N_LANES);
  localparam int unsigned      CNT_W      = cnt_width(OPEN_TIMEOUT, CLOSE_CYCLES);
  localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(N_LANES - 1);

  gate_state_e          state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 uni_q, uni_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [N_LANES-1:0]   lane_grant_q, lane_grant_d;
  logic [N_LANES-1:0]   lane_reject_q, lane_reject_d;
  logic                 gate_open_q, gate_open_d;
  logic                 car_entered_q, car_entered_d;
  logic                 is_uni_car_entered_q, is_uni_car_entered_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [N_LANES-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 eligible;
  logic [N_LANES-1:0]   win_onehot;

  parking_rr_arbiter #(
    .N_LANES (N_LANES),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (lane_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // University cars may overflow into general space; general cars may not use uni space.
  assign eligible   = parking_open &&
                      ((uni_q && (uni_vacated_space != '0)) || (vacated_space != '0));
  assign win_onehot = N_LANES'(1) << win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (parking_open && arb_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = eligible ? ST_OPEN : ST_IDLE;
      ST_OPEN:  if (car_passed || (cnt_q == '0)) state_d = ST_CLOSE;
      ST_CLOSE: if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d             = rr_ptr_q;
    win_d                = win_q;
    uni_d                = uni_q;
    cnt_d                = cnt_q;
    lane_grant_d         = '0;
    lane_reject_d        = '0;
    gate_open_d          = 1'b0;
    car_entered_d        = 1'b0;
    is_uni_car_entered_d = 1'b0;
    timeout_err_d        = 1'b0;
    busy_d               = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (parking_open && arb_valid) begin
          win_d = arb_idx;
          uni_d = |(arb_grant & lane_is_uni);
        end
      end
      ST_CHECK: begin
        rr_ptr_d = (win_q == LAST_LANE) ? '0 : win_q + IDX_W'(1);
        if (eligible) begin
          lane_grant_d = win_onehot;
          gate_open_d  = 1'b1;
          cnt_d        = OPEN_LOAD;
        end else begin
          lane_reject_d = win_onehot;
        end
      end
      ST_OPEN: begin
        // car_passed has priority over an expiring counter in the same cycle.
        if (car_passed) begin
          car_entered_d        = 1'b1;
          is_uni_car_entered_d = uni_q;
          cnt_d                = CLOSE_LOAD;
        end else if (cnt_q == '0) begin
          timeout_err_d = 1'b1;
          cnt_d         = CLOSE_LOAD;
        end else begin
          gate_open_d = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
        end
      end
      ST_CLOSE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q             <= '0;
      win_q                <= '0;
      uni_q                <= 1'b0;
      cnt_q                <= '0;
      lane_grant_q         <= '0;
      lane_reject_q        <= '0;
      gate_open_q          <= 1'b0;
      car_entered_q        <= 1'b0;
      is_uni_car_entered_q <= 1'b0;
      busy_q               <= 1'b0;
      timeout_err_q        <= 1'b0;
    end else begin
      rr_ptr_q             <= rr_ptr_d;
      win_q                <= win_d;
      uni_q                <= uni_d;
      cnt_q                <= cnt_d;
      lane_grant_q         <= lane_grant_d;
      lane_reject_q        <= lane_reject_d;
      gate_open_q          <= gate_open_d;
      car_entered_q        <= car_entered_d;
      is_uni_car_entered_q <= is_uni_car_entered_d;
      busy_q               <= busy_d;
      timeout_err_q        <= timeout_err_d;
    end
  end

  assign lane_grant         = lane_grant_q;
  assign lane_reject        = lane_reject_q;
  assign gate_open          = gate_open_q;
  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = is_uni_car_entered_q;
  assign busy               = busy_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed self-checking bench for parking_gate_scheduler (2 lanes, 32-cycle timeout, 2-cycle close).
module tb_parking_gate_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  lane_req;
  logic [1:0]  lane_is_uni;
  logic        parking_open;
  logic [31:0] uni_vacated_space;
  logic [31:0] vacated_space;
  logic        car_passed;
  logic [1:0]  lane_grant;
  logic [1:0]  lane_reject;
  logic        gate_open;
  logic        car_entered;
  logic        is_uni_car_entered;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  parking_gate_scheduler #(
    .N_LANES      (2),
    .OPEN_TIMEOUT (32),
    .CLOSE_CYCLES (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lane_req           (lane_req),
    .lane_is_uni        (lane_is_uni),
    .parking_open       (parking_open),
    .uni_vacated_space  (uni_vacated_space),
    .vacated_space      (vacated_space),
    .car_passed         (car_passed),
    .lane_grant         (lane_grant),
    .lane_reject        (lane_reject),
    .gate_open          (gate_open),
    .car_entered        (car_entered),
    .is_uni_car_entered (is_uni_car_entered),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] all_outs();
    return {lane_grant, lane_reject, gate_open, car_entered, is_uni_car_entered, busy, timeout_err};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("in_reset_outs", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_outs", 32'(all_outs()), 32'h0);
  endtask

  // Wait (bounded) for a grant or reject pulse; returns at the cycle it is visible.
  task automatic wait_decision(input string tag);
    int n;
    n = 0;
    while ((lane_grant == 2'b00) && (lane_reject == 2'b00) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(|{lane_grant, lane_reject}), 32'h1);
  endtask

  // Car clears the barrier: one-cycle entry pulse, then two closed cycles, then idle.
  task automatic pass_car(input string tag, input logic exp_uni);
    car_passed = 1'b1;
    tick();
    check({tag, "_entered"}, 32'(car_entered), 32'h1);
    check({tag, "_uni"}, 32'(is_uni_car_entered), 32'(exp_uni));
    check({tag, "_gate_closed"}, 32'(gate_open), 32'h0);
    car_passed = 1'b0;
    tick();
    check({tag, "_entered_1cyc"}, 32'(car_entered), 32'h0);
    tick();
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [8:0] acc;
    rst_n             = 1'b0;
    lane_req          = 2'b00;
    lane_is_uni       = 2'b00;
    parking_open      = 1'b1;
    uni_vacated_space = 32'd5;
    vacated_space     = 32'd5;
    car_passed        = 1'b0;
    do_reset();

    // Single uni car on lane 0: grant two edges after the request.
    lane_req    = 2'b01;
    lane_is_uni = 2'b01;
    tick();
    check("t2_check_busy", 32'(busy), 32'h1);
    check("t2_no_early_grant", 32'(lane_grant), 32'h0);
    tick();
    check("t2_grant", 32'(lane_grant), 32'h1);
    check("t2_gate_open", 32'(gate_open), 32'h1);
    check("t2_no_reject", 32'(lane_reject), 32'h0);
    lane_req = 2'b00;
    tick();
    check("t2_grant_1cyc", 32'(lane_grant), 32'h0);
    check("t2_gate_held", 32'(gate_open), 32'h1);
    pass_car("t2", 1'b1);

    // Both lanes requesting from reset: grants alternate, lane 1 is a general car.
    do_reset();
    lane_req    = 2'b11;
    lane_is_uni = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_decision("t3");
      check("t3_grant_order", 32'(lane_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      pass_car("t3", (k % 2 == 0));
    end
    lane_req = 2'b00;

    // Uni car overflows into general space.
    uni_vacated_space = 32'd0;
    vacated_space     = 32'd3;
    lane_req          = 2'b01;
    wait_decision("t4a");
    check("t4a_overflow_grant", 32'(lane_grant), 32'h1);
    lane_req = 2'b00;
    tick();
    pass_car("t4a", 1'b1);

    // Everything full: reject, barrier stays down.
    vacated_space = 32'd0;
    lane_req      = 2'b10;
    wait_decision("t4b");
    check("t4b_reject", 32'(lane_reject), 32'h2);
    check("t4b_no_grant", 32'(lane_grant), 32'h0);
    check("t4b_gate", 32'(gate_open), 32'h0);
    lane_req = 2'b00;
    tick();
    check("t4b_gate_after", 32'(gate_open), 32'h0);
    check("t4b_idle", 32'(busy), 32'h0);

    // General car cannot take university space.
    uni_vacated_space = 32'd5;
    lane_is_uni       = 2'b00;
    lane_req          = 2'b01;
    wait_decision("t4c");
    check("t4c_general_reject", 32'(lane_reject), 32'h1);
    lane_req = 2'b00;
    tick();

    // Timeout: gate held 32 cycles, then error pulse and two closed cycles.
    vacated_space = 32'd5;
    lane_req      = 2'b01;
    wait_decision("t5");
    check("t5_grant", 32'(lane_grant), 32'h1);
    lane_req = 2'b00;
    repeat (31) tick();
    check("t5_gate_still_open", 32'(gate_open), 32'h1);
    check("t5_no_early_timeout", 32'(timeout_err), 32'h0);
    tick();
    check("t5_timeout", 32'(timeout_err), 32'h1);
    check("t5_no_entry", 32'(car_entered), 32'h0);
    check("t5_gate_closed", 32'(gate_open), 32'h0);
    car_passed = 1'b1;
    tick();
    check("t5_timeout_1cyc", 32'(timeout_err), 32'h0);
    check("t5_close_busy", 32'(busy), 32'h1);
    check("t5_pass_in_close_ignored", 32'(car_entered), 32'h0);
    tick();
    check("t5_idle", 32'(busy), 32'h0);
    check("t5_pass_in_close_ignored2", 32'(car_entered), 32'h0);
    tick();
    check("t5_pass_in_idle_ignored", 32'(car_entered | busy), 32'h0);
    car_passed = 1'b0;

    // Window closed: requests produce no activity.
    parking_open = 1'b0;
    lane_req     = 2'b11;
    acc          = '0;
    repeat (5) begin
      tick();
      acc = acc | all_outs();
    end
    check("t6_closed_quiet", 32'(acc), 32'h0);

    // Window reopens (pointer now at lane 1), then closes while the gate is open.
    parking_open = 1'b1;
    wait_decision("t6");
    check("t6_grant_lane1", 32'(lane_grant), 32'h2);
    lane_req     = 2'b00;
    parking_open = 1'b0;
    tick();
    check("t6_gate_kept_open", 32'(gate_open), 32'h1);
    pass_car("t6", 1'b0);

    // Window closes while the candidate is being checked: forced reject.
    parking_open = 1'b1;
    lane_req     = 2'b01;
    tick();
    parking_open = 1'b0;
    tick();
    check("t6_check_close_reject", 32'(lane_reject), 32'h1);
    check("t6_check_close_no_grant", 32'(lane_grant), 32'h0);
    lane_req     = 2'b00;
    parking_open = 1'b1;
    tick();

    // Reset mid-OPEN drops the barrier immediately and leaves no pending pulse.
    lane_req = 2'b01;
    wait_decision("t1");
    check("t1_grant", 32'(lane_grant), 32'h1);
    lane_req = 2'b00;
    tick();
    check("t1_gate_before_reset", 32'(gate_open), 32'h1);
    car_passed = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("t1_gate_async_drop", 32'(gate_open), 32'h0);
    check("t1_busy_async_drop", 32'(busy), 32'h0);
    tick();
    car_passed = 1'b0;
    rst_n      = 1'b1;
    tick();
    check("t1_outs_after_release", 32'(all_outs()), 32'h0);
    tick();
    check("t1_no_pending_pulse", 32'(all_outs()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
